ddr5_phy_ca_cmd_scheduler: RTL and testbench
============================================

# ddr5_phy_ca_cmd_scheduler

Arbitrates and sequences DDR5 commands onto the DFI command/address inputs of the PHY command/address manager. Two requesters share the CA path: a mode-register-write (MRW) configuration port and a host command port. The scheduler serializes one- and two-cycle commands, encodes MRW cycles, enforces inter-command gaps, and brings the CA manager out of its default-initialization cycle before issuing any command.

## Interface
- pNUM_RANK, 1, number of ranks; width of every chip-select vector
- pMRD_CYCLES, 8, deselect cycles after an MRW (1..15)
- pCMD_GAP, 1, deselect cycles after a host command (0..15)

- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- mrw_req_i  in  1  MRW request, held until ack
- mrw_cs_n_i  in  pNUM_RANK  active-low target ranks for MRW
- mrw_ma_i  in  8  mode register address
- mrw_op_i  in  8  mode register operand
- mrw_ack_o  out  1  one-cycle MRW acceptance pulse
- cmd_req_i  in  1  host command request, held until ack
- cmd_cs_n_i  in  pNUM_RANK  active-low target ranks
- cmd_ca1_i  in  14  first-cycle CA
- cmd_ca2_i  in  14  second-cycle CA
- cmd_two_cycle_i  in  1  1 = two-cycle command
- cmd_ack_o  out  1  one-cycle host acceptance pulse
- ca_enable_o  out  1  enable to CA manager
- dfi_address_o  out  14  CA to CA manager
- dfi_cs_o  out  pNUM_RANK  chip select to CA manager
- busy_o  out  1  high in every state except IDLE

## Operation
- All outputs registered. Reset values: ca_enable_o=0, dfi_address_o=0, dfi_cs_o=all ones, acks=0, busy_o=1, state=INIT, RR pointer=MRW.
- FSM states: INIT, IDLE, CYC1, CYC2, GAP.
- INIT: lasts one cycle; drives ca_enable_o=1 with deselect (cs all ones, CA 0), which is the CA manager default-load cycle. Then transitions to IDLE. ca_enable_o stays 1 until reset.
- IDLE: outputs deselect. If any request is high, grant, capture the payload, pulse the matching ack, and go to CYC1.
- Arbitration: round-robin. If only one port requests, it wins. If both request, the port named by the pointer wins, and the pointer then flips to the other port. A pointer update happens only on a grant.
- MRW encoding:
  - CYC1: CA[4:0]=5'b00101, CA[12:5]=ma, CA[13]=0, cs=mrw_cs_n.
  - CYC2: CA[7:0]=op, CA[10]=0, all other bits 0, cs=all ones.
- Host encoding:
  - CYC1: CA=ca1, cs=cmd_cs_n.
  - CYC2, only if two_cycle: CA=ca2, cs=all ones.
  - A one-cycle command skips CYC2.
- Gap counter (4 bits):
  - On leaving the last command cycle, load pMRD_CYCLES for an MRW or pCMD_GAP for a host command.
  - GAP decrements each cycle with deselect outputs and returns to IDLE on reaching 1.
  - A load value of 0 bypasses GAP and goes straight to IDLE.
- Requests are not sampled outside IDLE. Payload changes after ack are ignored.
- A requester must deassert req in the cycle after ack, otherwise it is granted again on the next IDLE.
- Reset asserted mid-command: outputs immediately take their reset values and the in-flight command is dropped. After release the sequence restarts at INIT.

## Timing
- Request seen high at IDLE edge N: ack and CYC1 outputs are valid in cycle N+1; CYC2 is valid in N+2.
- Back-to-back MRW: the next CYC1 comes no earlier than 2+pMRD_CYCLES+1 cycles after the previous CYC1. This spacing is 2 command cycles, the gap, and one IDLE cycle.
- Host one-cycle command with pCMD_GAP=0: the next CYC1 comes at the earliest 2 cycles later (CYC1, IDLE).
- The first command after reset release reaches the CA bus no earlier than cycle 3: INIT, IDLE sample, CYC1.
- Exactly one ack pulse per grant, aligned with CYC1.

## Configuration
- CA_SCHED_MR_SHADOW_EN:
  - When defined, adds outputs mr0_shadow_o[7:0], mr8_shadow_o[7:0] and mr50_shadow_o[7:0].
  - Reset values are 8'h00, 8'h08 and 8'h00.
  - Each updates in the CYC2 cycle of an MRW to MA 0, 8 or 50 with that MRW's op.
  - These give upstream logic the active burst length, preamble/postamble and CRC settings without readback.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

## Test plan
- Reset release, no requests: cycle 1 ca_enable_o=1 with cs=all ones; then IDLE, busy_o=0 from cycle 2.
- MRW ma=8, op=8'h90, cs_n=0: CYC1 CA=14'h0105; CYC2 CA=14'h0090 with cs=1; ack in CYC1; then 8 GAP cycles; IDLE on the 9th.
- mrw_req and cmd_req both held continuously after reset: grants alternate MRW, CMD, MRW; each ack is one cycle; gaps are 8 and 1 respectively.
- Host one-cycle command, ca1=14'h000D, pCMD_GAP=0: only CYC1 is driven; back to IDLE the next cycle; ack once.
- Reset pulsed during CYC2 of an MRW: outputs are at reset values in the same cycle; after release INIT replays; no ack is reissued without a request.
- With CA_SCHED_MR_SHADOW_EN defined, MRW ma=50, op=8'h01: mr50_shadow_o=8'h01 from the CYC2 cycle onward; other shadows unchanged.

Source files
------------

// File: rtl/ddr5_phy_ca_cmd_scheduler.sv
// DDR5 CA command scheduler: round-robin MRW/host arbitration, MRW encoding and post-command gaps.
// Optional feature macro CA_SCHED_MR_SHADOW_EN adds MR0/MR8/MR50 shadow outputs.
module ddr5_phy_ca_cmd_scheduler #(
    parameter int unsigned pNUM_RANK   = 1,
    parameter int unsigned pMRD_CYCLES = 8,
    parameter int unsigned pCMD_GAP    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mrw_req_i,
    input  logic [pNUM_RANK-1:0] mrw_cs_n_i,
    input  logic [7:0]           mrw_ma_i,
    input  logic [7:0]           mrw_op_i,
    output logic                 mrw_ack_o,
    input  logic                 cmd_req_i,
    input  logic [pNUM_RANK-1:0] cmd_cs_n_i,
    input  logic [13:0]          cmd_ca1_i,
    input  logic [13:0]          cmd_ca2_i,
    input  logic                 cmd_two_cycle_i,
    output logic                 cmd_ack_o,
    output logic                 ca_enable_o,
    output logic [13:0]          dfi_address_o,
    output logic [pNUM_RANK-1:0] dfi_cs_o,
    output logic                 busy_o
`ifdef CA_SCHED_MR_SHADOW_EN
    ,
    output logic [7:0]           mr0_shadow_o,
    output logic [7:0]           mr8_shadow_o,
    output logic [7:0]           mr50_shadow_o
`endif
);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_CYC1, ST_CYC2, ST_GAP} state_e;
    typedef enum logic {PORT_MRW, PORT_CMD} port_e;

    localparam logic [3:0]           MRD_LOAD = 4'(pMRD_CYCLES);
    localparam logic [3:0]           CMD_LOAD = 4'(pCMD_GAP);
    localparam logic [pNUM_RANK-1:0] CS_DESEL = '1;
    localparam logic [4:0]           MRW_OPC  = 5'b00101;

    state_e                 state_q, state_d;
    port_e                  rr_q, rr_d;
    logic                   ca_en_q, ca_en_d;
    logic [13:0]            addr_q, addr_d;
    logic [pNUM_RANK-1:0]   cs_q, cs_d;
    logic                   mrw_ack_q, mrw_ack_d;
    logic                   cmd_ack_q, cmd_ack_d;
    logic                   busy_q, busy_d;
    logic [3:0]             gap_q, gap_d;
    logic                   sel_mrw_q, sel_mrw_d;
    logic [7:0]             op_q, op_d;
    logic [13:0]            ca2_q, ca2_d;
    logic                   two_q, two_d;
    logic                   grant_mrw;
    logic [3:0]             gap_load;

    assign gap_load = sel_mrw_q ? MRD_LOAD : CMD_LOAD;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        ca_en_d   = ca_en_q;
        addr_d    = '0;
        cs_d      = CS_DESEL;
        mrw_ack_d = 1'b0;
        cmd_ack_d = 1'b0;
        gap_d     = gap_q;
        sel_mrw_d = sel_mrw_q;
        op_d      = op_q;
        ca2_d     = ca2_q;
        two_d     = two_q;
        grant_mrw = 1'b0;

        unique case (state_q)
            // The reset-value cycle is followed by one default-load cycle with enable up.
            ST_INIT: begin
                ca_en_d = 1'b1;
                if (ca_en_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (mrw_req_i || cmd_req_i) begin
                    grant_mrw = mrw_req_i && (!cmd_req_i || rr_q == PORT_MRW);
                    rr_d      = grant_mrw ? PORT_CMD : PORT_MRW;
                    sel_mrw_d = grant_mrw;
                    state_d   = ST_CYC1;
                    if (grant_mrw) begin
                        addr_d    = {1'b0, mrw_ma_i, MRW_OPC};
                        cs_d      = mrw_cs_n_i;
                        mrw_ack_d = 1'b1;
                        op_d      = mrw_op_i;
                    end else begin
                        addr_d    = cmd_ca1_i;
                        cs_d      = cmd_cs_n_i;
                        cmd_ack_d = 1'b1;
                        ca2_d     = cmd_ca2_i;
                        two_d     = cmd_two_cycle_i;
                    end
                end
            end
            ST_CYC1: begin
                if (sel_mrw_q || two_q) begin
                    state_d = ST_CYC2;
                    addr_d  = sel_mrw_q ? {6'b0, op_q} : ca2_q;
                end else begin
                    gap_d   = gap_load;
                    state_d = (gap_load == 4'd0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_CYC2: begin
                gap_d   = gap_load;
                state_d = (gap_load == 4'd0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_INIT;
            rr_q      <= PORT_MRW;
            ca_en_q   <= 1'b0;
            addr_q    <= '0;
            cs_q      <= CS_DESEL;
            mrw_ack_q <= 1'b0;
            cmd_ack_q <= 1'b0;
            busy_q    <= 1'b1;
            gap_q     <= '0;
            sel_mrw_q <= 1'b0;
            op_q      <= '0;
            ca2_q     <= '0;
            two_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            ca_en_q   <= ca_en_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            mrw_ack_q <= mrw_ack_d;
            cmd_ack_q <= cmd_ack_d;
            busy_q    <= busy_d;
            gap_q     <= gap_d;
            sel_mrw_q <= sel_mrw_d;
            op_q      <= op_d;
            ca2_q     <= ca2_d;
            two_q     <= two_d;
        end
    end

    assign ca_enable_o   = ca_en_q;
    assign dfi_address_o = addr_q;
    assign dfi_cs_o      = cs_q;
    assign mrw_ack_o     = mrw_ack_q;
    assign cmd_ack_o     = cmd_ack_q;
    assign busy_o        = busy_q;

`ifdef CA_SCHED_MR_SHADOW_EN
    logic [7:0] ma_q;
    logic [7:0] mr0_q, mr0_d, mr8_q, mr8_d, mr50_q, mr50_d;

    // Shadows change on the edge that enters CYC2, together with the operand on the bus.
    always_comb begin
        mr0_d  = mr0_q;
        mr8_d  = mr8_q;
        mr50_d = mr50_q;
        if (state_q == ST_CYC1 && sel_mrw_q) begin
            case (ma_q)
                8'd0:    mr0_d  = op_q;
                8'd8:    mr8_d  = op_q;
                8'd50:   mr50_d = op_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ma_q   <= '0;
            mr0_q  <= 8'h00;
            mr8_q  <= 8'h08;
            mr50_q <= 8'h00;
        end else begin
            if (state_q == ST_IDLE && grant_mrw) ma_q <= mrw_ma_i;
            mr0_q  <= mr0_d;
            mr8_q  <= mr8_d;
            mr50_q <= mr50_d;
        end
    end

    assign mr0_shadow_o  = mr0_q;
    assign mr8_shadow_o  = mr8_q;
    assign mr50_shadow_o = mr50_q;
`endif

endmodule

// File: tb/tb_ddr5_phy_ca_cmd_scheduler.sv
// Directed bench for ddr5_phy_ca_cmd_scheduler: u0 uses default gaps, u1 uses a zero host gap.
// Cycle k below is the period just after the k-th rising edge following reset release.
module tb_ddr5_phy_ca_cmd_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mrw_req_i = 1'b0;
    logic [0:0]  mrw_cs_n_i = 1'b1;
    logic [7:0]  mrw_ma_i = '0;
    logic [7:0]  mrw_op_i = '0;
    logic        cmd_req_i = 1'b0;
    logic [0:0]  cmd_cs_n_i = 1'b1;
    logic [13:0] cmd_ca1_i = '0;
    logic [13:0] cmd_ca2_i = '0;
    logic        cmd_two_cycle_i = 1'b0;

    logic        mrw_ack_o, cmd_ack_o, ca_enable_o, busy_o;
    logic [13:0] dfi_address_o;
    logic [0:0]  dfi_cs_o;
    logic        g0_mrw_ack_o, g0_cmd_ack_o, g0_ca_enable_o, g0_busy_o;
    logic [13:0] g0_dfi_address_o;
    logic [0:0]  g0_dfi_cs_o;
`ifdef CA_SCHED_MR_SHADOW_EN
    logic [7:0]  mr0_shadow_o, mr8_shadow_o, mr50_shadow_o;
    logic [7:0]  g0_mr0_shadow_o, g0_mr8_shadow_o, g0_mr50_shadow_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef logic [18:0] obs_t;

    always #5 clk_i = ~clk_i;

    ddr5_phy_ca_cmd_scheduler #(.pNUM_RANK(1), .pMRD_CYCLES(8), .pCMD_GAP(1)) u0 (
        .clk_i(clk_i), .rst_i(rst_i),
        .mrw_req_i(mrw_req_i), .mrw_cs_n_i(mrw_cs_n_i), .mrw_ma_i(mrw_ma_i), .mrw_op_i(mrw_op_i),
        .mrw_ack_o(mrw_ack_o),
        .cmd_req_i(cmd_req_i), .cmd_cs_n_i(cmd_cs_n_i), .cmd_ca1_i(cmd_ca1_i), .cmd_ca2_i(cmd_ca2_i),
        .cmd_two_cycle_i(cmd_two_cycle_i), .cmd_ack_o(cmd_ack_o),
        .ca_enable_o(ca_enable_o), .dfi_address_o(dfi_address_o), .dfi_cs_o(dfi_cs_o), .busy_o(busy_o)
`ifdef CA_SCHED_MR_SHADOW_EN
        , .mr0_shadow_o(mr0_shadow_o), .mr8_shadow_o(mr8_shadow_o), .mr50_shadow_o(mr50_shadow_o)
`endif
    );

    ddr5_phy_ca_cmd_scheduler #(.pNUM_RANK(1), .pMRD_CYCLES(8), .pCMD_GAP(0)) u1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .mrw_req_i(mrw_req_i), .mrw_cs_n_i(mrw_cs_n_i), .mrw_ma_i(mrw_ma_i), .mrw_op_i(mrw_op_i),
        .mrw_ack_o(g0_mrw_ack_o),
        .cmd_req_i(cmd_req_i), .cmd_cs_n_i(cmd_cs_n_i), .cmd_ca1_i(cmd_ca1_i), .cmd_ca2_i(cmd_ca2_i),
        .cmd_two_cycle_i(cmd_two_cycle_i), .cmd_ack_o(g0_cmd_ack_o),
        .ca_enable_o(g0_ca_enable_o), .dfi_address_o(g0_dfi_address_o), .dfi_cs_o(g0_dfi_cs_o),
        .busy_o(g0_busy_o)
`ifdef CA_SCHED_MR_SHADOW_EN
        , .mr0_shadow_o(g0_mr0_shadow_o), .mr8_shadow_o(g0_mr8_shadow_o), .mr50_shadow_o(g0_mr50_shadow_o)
`endif
    );

    // Packed order: {ca_enable, address, cs, mrw_ack, cmd_ack, busy}.
    function automatic obs_t pk(input logic en, input logic [13:0] a, input logic cs,
                                input logic ma, input logic ca, input logic b);
        return {en, a, cs, ma, ca, b};
    endfunction

    function automatic obs_t obs0();
        return pk(ca_enable_o, dfi_address_o, dfi_cs_o[0], mrw_ack_o, cmd_ack_o, busy_o);
    endfunction

    function automatic obs_t obs1();
        return pk(g0_ca_enable_o, g0_dfi_address_o, g0_dfi_cs_o[0], g0_mrw_ack_o, g0_cmd_ack_o, g0_busy_o);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mrw_req_i = 1'b0; mrw_cs_n_i = 1'b1; mrw_ma_i = '0; mrw_op_i = '0;
        cmd_req_i = 1'b0; cmd_cs_n_i = 1'b1; cmd_ca1_i = '0; cmd_ca2_i = '0; cmd_two_cycle_i = 1'b0;
    endtask

    // Leaves the bench at cycle 0 (reset just released, INIT pending).
    task automatic do_reset();
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) step();
        e = pk(1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL reset_hold_u0: got %h want %h", obs0(), e); end
        checks++;
        if (obs1() !== e) begin errors++; $display("FAIL reset_hold_u1: got %h want %h", obs1(), e); end
        rst_i = 1'b1;
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL reset_c0: got %h want %h", obs0(), e); end
        step();
        e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL init_load_c1: got %h want %h", obs0(), e); end
        for (int c = 2; c <= 3; c++) begin
            step();
            e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs0() !== e) begin errors++; $display("FAIL reset_idle_c%0d: got %h want %h", c, obs0(), e); end
        end
    endtask

    task automatic test_mrw();
        obs_t e;
        do_reset();
        repeat (2) step();
        mrw_req_i = 1'b1; mrw_cs_n_i = 1'b0; mrw_ma_i = 8'd8; mrw_op_i = 8'h90;
        step();
        e = pk(1'b1, 14'h0105, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL mrw_cyc1: got %h want %h", obs0(), e); end
        mrw_req_i = 1'b0; mrw_ma_i = 8'hFF; mrw_op_i = 8'h55; mrw_cs_n_i = 1'b1;
        step();
        e = pk(1'b1, 14'h0090, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL mrw_cyc2: got %h want %h", obs0(), e); end
        for (int i = 1; i <= 8; i++) begin
            step();
            e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs0() !== e) begin errors++; $display("FAIL mrw_gap%0d: got %h want %h", i, obs0(), e); end
        end
        step();
        e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL mrw_idle: got %h want %h", obs0(), e); end
    endtask

    task automatic test_arbitration();
        obs_t e;
        do_reset();
        mrw_req_i = 1'b1; mrw_cs_n_i = 1'b0; mrw_ma_i = 8'h12; mrw_op_i = 8'h34;
        cmd_req_i = 1'b1; cmd_cs_n_i = 1'b0; cmd_ca1_i = 14'h1ABC; cmd_two_cycle_i = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            step();
            case (c)
                1:       e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
                2, 13, 16: e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
                3, 17:   e = pk(1'b1, 14'h0245, 1'b0, 1'b1, 1'b0, 1'b1);
                4:       e = pk(1'b1, 14'h0034, 1'b1, 1'b0, 1'b0, 1'b1);
                14:      e = pk(1'b1, 14'h1ABC, 1'b0, 1'b0, 1'b1, 1'b1);
                default: e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
            endcase
            checks++;
            if (obs0() !== e) begin errors++; $display("FAIL arb_c%0d: got %h want %h", c, obs0(), e); end
        end
        idle_inputs();
    endtask

    task automatic test_host_one_cycle();
        obs_t e;
        do_reset();
        repeat (2) step();
        cmd_req_i = 1'b1; cmd_cs_n_i = 1'b0; cmd_ca1_i = 14'h000D; cmd_two_cycle_i = 1'b0;
        step();
        e = pk(1'b1, 14'h000D, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (obs1() !== e) begin errors++; $display("FAIL host1_cyc1: got %h want %h", obs1(), e); end
        idle_inputs();
        step();
        e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs1() !== e) begin errors++; $display("FAIL host1_idle: got %h want %h", obs1(), e); end
        e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL host1_gap1_u0: got %h want %h", obs0(), e); end
        step();
        e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs1() !== e) begin errors++; $display("FAIL host1_no_reack: got %h want %h", obs1(), e); end
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL host1_idle_u0: got %h want %h", obs0(), e); end
    endtask

    task automatic test_host_two_cycle();
        obs_t e;
        do_reset();
        repeat (2) step();
        cmd_req_i = 1'b1; cmd_cs_n_i = 1'b0; cmd_ca1_i = 14'h2001; cmd_ca2_i = 14'h0ABC; cmd_two_cycle_i = 1'b1;
        step();
        e = pk(1'b1, 14'h2001, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL host2_cyc1: got %h want %h", obs0(), e); end
        cmd_req_i = 1'b0; cmd_ca2_i = 14'h3FFF; cmd_two_cycle_i = 1'b0;
        step();
        e = pk(1'b1, 14'h0ABC, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL host2_cyc2: got %h want %h", obs0(), e); end
        step();
        e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL host2_gap: got %h want %h", obs0(), e); end
        step();
        e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL host2_idle: got %h want %h", obs0(), e); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        obs_t e;
        do_reset();
        repeat (2) step();
        cmd_req_i = 1'b1; cmd_cs_n_i = 1'b0; cmd_ca1_i = 14'h0011; cmd_two_cycle_i = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            step();
            if (c == 5) idle_inputs();
            if (c == 3 || c == 5) e = pk(1'b1, 14'h0011, 1'b0, 1'b0, 1'b1, 1'b1);
            else                  e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs1() !== e) begin errors++; $display("FAIL b2b_c%0d: got %h want %h", c, obs1(), e); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        do_reset();
        repeat (2) step();
        mrw_req_i = 1'b1; mrw_cs_n_i = 1'b0; mrw_ma_i = 8'd8; mrw_op_i = 8'h90;
        step();
        idle_inputs();
        step();
        e = pk(1'b1, 14'h0090, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL rmid_cyc2: got %h want %h", obs0(), e); end
        rst_i = 1'b0;
        #1;
        e = pk(1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs0() !== e) begin errors++; $display("FAIL rmid_async: got %h want %h", obs0(), e); end
        #1;
        rst_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            e = pk(1'b1, 14'h0000, 1'b1, 1'b0, 1'b0, (c == 1) ? 1'b1 : 1'b0);
            checks++;
            if (obs0() !== e) begin errors++; $display("FAIL rmid_replay_c%0d: got %h want %h", c, obs0(), e); end
        end
    endtask

`ifdef CA_SCHED_MR_SHADOW_EN
    task automatic test_shadow();
        do_reset();
        checks++;
        if ({mr0_shadow_o, mr8_shadow_o, mr50_shadow_o} !== 24'h000800) begin
            errors++; $display("FAIL shadow_reset: got %h want 000800", {mr0_shadow_o, mr8_shadow_o, mr50_shadow_o});
        end
        repeat (2) step();
        mrw_req_i = 1'b1; mrw_cs_n_i = 1'b0; mrw_ma_i = 8'd50; mrw_op_i = 8'h01;
        step();
        idle_inputs();
        checks++;
        if (mr50_shadow_o !== 8'h00) begin errors++; $display("FAIL shadow_cyc1: got %h want 00", mr50_shadow_o); end
        for (int c = 4; c <= 6; c++) begin
            step();
            checks++;
            if ({mr0_shadow_o, mr8_shadow_o, mr50_shadow_o} !== 24'h000801) begin
                errors++;
                $display("FAIL shadow_c%0d: got %h want 000801", c, {mr0_shadow_o, mr8_shadow_o, mr50_shadow_o});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mrw();
        test_arbitration();
        test_host_one_cycle();
        test_host_two_cycle();
        test_back_to_back();
        test_reset_mid();
`ifdef CA_SCHED_MR_SHADOW_EN
        test_shadow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
